// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read-channel (AR + R) signal bundle with master/slave modports
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  // Issuer of read requests (drives AR payload and rready)
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  // Responder to read requests (drives arready and the R payload)
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin arbiter for AXI4 AR/R, one burst in flight
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_arbiter_if.slave   m0,
  axi_rd_arbiter_if.slave   m1,
  axi_rd_arbiter_if.master  s
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;

  // Winner of the current burst and the master preferred on the next tie
  logic                  grant_q;
  logic                  prio_q;

  // Registered AR payload presented to the slave
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;

  logic                  sel;
  logic                  ar_hs;
  logic                  s_ar_hs;
  logic                  rready_sel;
  logic                  r_done;

  // Pick the requester: a lone requester wins, a tie goes to prio
  always_comb begin
    if (m0.arvalid && m1.arvalid) begin
      sel = prio_q;
    end else begin
      sel = m1.arvalid;
    end
  end

  // Handshake and burst-completion strobes shared by the FSM and datapath
  always_comb begin
    ar_hs      = rst && (state_q == ST_IDLE) && (m0.arvalid || m1.arvalid);
    s_ar_hs    = (state_q == ST_AR) && s.arready;
    rready_sel = grant_q ? m1.rready : m0.rready;
    r_done     = (state_q == ST_R) && s.rvalid && rready_sel && s.rlast;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept one request, forward it, then pass data until rlast
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ar_hs)   state_d = ST_AR;
      ST_AR:   if (s_ar_hs) state_d = ST_R;
      ST_R:    if (r_done)  state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Outputs: arready only in IDLE, AR valid in AR, R pass-through to the grantee in R
  always_comb begin
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = 2'b00;
    m0.rlast   = 1'b0;
    m0.rid     = '0;
    m1.rvalid  = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = 2'b00;
    m1.rlast   = 1'b0;
    m1.rid     = '0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so requests are never acknowledged while held in reset
        m0.arready = rst && m0.arvalid && !sel;
        m1.arready = rst && m1.arvalid && sel;
      end
      ST_AR: begin
        s.arvalid = 1'b1;
      end
      ST_R: begin
        s.rready = rready_sel;
        if (!grant_q) begin
          m0.rvalid = s.rvalid;
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
          m0.rlast  = s.rlast;
          m0.rid    = s.rid;
        end else begin
          m1.rvalid = s.rvalid;
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
          m1.rlast  = s.rlast;
          m1.rid    = s.rid;
        end
      end
      default: ;
    endcase
  end

  assign s.araddr  = ar_addr_q;
  assign s.arid    = ar_id_q;
  assign s.arlen   = ar_len_q;
  assign s.arsize  = ar_size_q;
  assign s.arburst = ar_burst_q;

  // Latch the winner and its payload on accept; hand priority away after rlast
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
    end else begin
      if (ar_hs) begin
        grant_q    <= sel;
        ar_addr_q  <= sel ? m1.araddr  : m0.araddr;
        ar_id_q    <= sel ? m1.arid    : m0.arid;
        ar_len_q   <= sel ? m1.arlen   : m0.arlen;
        ar_size_q  <= sel ? m1.arsize  : m0.arsize;
        ar_burst_q <= sel ? m1.arburst : m0.arburst;
      end
      if (r_done) begin
        prio_q <= ~grant_q;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) m0_if ();
  axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) m1_if ();
  axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) s_if ();

  axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master request streams and per-master bookkeeping
  ar_t  q0[$];
  ar_t  q1[$];
  ar_t  cur [2];
  bit   pend [2];
  int   beats [2];
  logic [31:0] last_data [2];
  int   glog[$];

  // Transaction-level arbiter model: 0 idle, 1 address to slave, 2 data
  int   a_phase;
  int   a_grant;
  int   a_prio;
  ar_t  exp_ar;

  // Slave responder state
  bit          s_have;
  bit          s_offer;
  int          s_cnt;
  int          s_len;
  int          s_dly;
  logic [3:0]  s_id;
  logic [31:0] s_data;
  logic [1:0]  s_resp;

  // Stimulus knobs
  int   dly_fixed  = -1;
  bit   rv_always  = 1'b0;
  bit   fixed_data = 1'b0;
  bit   junk_en    = 1'b0;
  bit   rand_issue = 1'b0;
  int   rr_mode    = 2;
  int   rr_idx     = 0;
  bit [3:0] rr_pat = 4'b1001;
  logic rready_drv [2];
  logic s_arready_drv;

  function automatic ar_t mk_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    ar_t a;
    a.addr  = addr;
    a.id    = id;
    a.len   = len;
    a.size  = 3'd2;
    a.burst = 2'd1;
    return a;
  endfunction

  function automatic int new_dly();
    if (dly_fixed >= 0) return dly_fixed;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    glog.delete();
    for (int i = 0; i < 2; i++) begin
      cur[i]       = '0;
      pend[i]      = 1'b0;
      beats[i]     = 0;
      last_data[i] = 32'h0;
      rready_drv[i] = 1'b0;
    end
    a_phase = 0;
    a_grant = 0;
    a_prio  = 0;
    exp_ar  = '0;
    s_have  = 1'b0;
    s_offer = 1'b0;
    s_cnt   = 0;
    s_len   = 0;
    s_id    = 4'h0;
    s_data  = 32'h0;
    s_resp  = 2'b00;
    s_dly   = new_dly();
    rr_idx  = 0;
    s_arready_drv = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_if.arvalid = 1'b0; m0_if.araddr = 32'h0; m0_if.arid = 4'h0; m0_if.arlen = 8'h0;
    m0_if.arsize = 3'h0;  m0_if.arburst = 2'h0; m0_if.rready = 1'b0;
    m1_if.arvalid = 1'b0; m1_if.araddr = 32'h0; m1_if.arid = 4'h0; m1_if.arlen = 8'h0;
    m1_if.arsize = 3'h0;  m1_if.arburst = 2'h0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0;  s_if.rvalid = 1'b0;   s_if.rdata = 32'h0;
    s_if.rresp = 2'h0;    s_if.rlast = 1'b0;    s_if.rid = 4'h0;
  endtask

  task automatic drive();
    if (!pend[0] && q0.size() > 0 && (!rand_issue || $urandom_range(0, 2) != 0)) begin
      cur[0]  = q0.pop_front();
      pend[0] = 1'b1;
    end
    if (!pend[1] && q1.size() > 0 && (!rand_issue || $urandom_range(0, 2) != 0)) begin
      cur[1]  = q1.pop_front();
      pend[1] = 1'b1;
    end
    m0_if.arvalid = pend[0]; m0_if.araddr = cur[0].addr; m0_if.arid = cur[0].id;
    m0_if.arlen = cur[0].len; m0_if.arsize = cur[0].size; m0_if.arburst = cur[0].burst;
    m1_if.arvalid = pend[1]; m1_if.araddr = cur[1].addr; m1_if.arid = cur[1].id;
    m1_if.arlen = cur[1].len; m1_if.arsize = cur[1].size; m1_if.arburst = cur[1].burst;
    for (int i = 0; i < 2; i++) begin
      case (rr_mode)
        0:       rready_drv[i] = ($urandom_range(0, 3) != 0);
        1:       rready_drv[i] = (rr_idx < 4) ? rr_pat[rr_idx[1:0]] : 1'b1;
        default: rready_drv[i] = 1'b1;
      endcase
    end
    m0_if.rready = rready_drv[0];
    m1_if.rready = rready_drv[1];
    s_arready_drv = s_if.arvalid && (s_dly == 0);
    s_if.arready  = s_arready_drv;
    if (s_have) begin
      if (!s_offer && (rv_always || $urandom_range(0, 2) != 0)) begin
        s_offer = 1'b1;
        s_data  = fixed_data ? 32'(32'h11 * (s_cnt + 1)) : $urandom();
        s_resp  = 2'($urandom_range(0, 3));
      end
      s_if.rvalid = s_offer;
      s_if.rdata  = s_data;
      s_if.rresp  = s_resp;
      s_if.rlast  = (s_cnt == s_len);
      s_if.rid    = s_id;
    end else begin
      s_if.rvalid = junk_en && ($urandom_range(0, 3) == 0);
      s_if.rdata  = $urandom();
      s_if.rresp  = 2'($urandom_range(0, 3));
      s_if.rlast  = 1'($urandom_range(0, 1));
      s_if.rid    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic observe();
    bit any;
    int sel;
    int g;
    bit in_r;
    logic [38:0] sr;
    logic [38:0] exp0;
    logic [38:0] exp1;
    any  = pend[0] || pend[1];
    sel  = (pend[0] && pend[1]) ? a_prio : (pend[1] ? 1 : 0);
    in_r = (a_phase == 2);
    g    = a_grant;
    sr   = {s_if.rdata, s_if.rresp, s_if.rlast, s_if.rid};
    exp0 = (in_r && g == 0) ? sr : 39'h0;
    exp1 = (in_r && g == 1) ? sr : 39'h0;
    check("m0_arready", 64'(m0_if.arready), 64'(a_phase == 0 && any && sel == 0));
    check("m1_arready", 64'(m1_if.arready), 64'(a_phase == 0 && any && sel == 1));
    check("s_arvalid", 64'(s_if.arvalid), 64'(a_phase == 1));
    if (a_phase == 1)
      check("s_ar_payload", 64'({s_if.araddr, s_if.arid, s_if.arlen, s_if.arsize, s_if.arburst}), 64'(exp_ar));
    check("m0_rvalid", 64'(m0_if.rvalid), 64'(in_r && g == 0 && s_if.rvalid));
    check("m1_rvalid", 64'(m1_if.rvalid), 64'(in_r && g == 1 && s_if.rvalid));
    check("m0_rpayload", 64'({m0_if.rdata, m0_if.rresp, m0_if.rlast, m0_if.rid}), 64'(exp0));
    check("m1_rpayload", 64'({m1_if.rdata, m1_if.rresp, m1_if.rlast, m1_if.rid}), 64'(exp1));
    check("s_rready", 64'(s_if.rready), 64'(in_r && rready_drv[g]));

    if (a_phase == 0 && any) begin
      a_phase   = 1;
      a_grant   = sel;
      exp_ar    = cur[sel];
      pend[sel] = 1'b0;
      beats[sel] = 0;
      glog.push_back(sel);
    end else if (a_phase == 1) begin
      if (s_arready_drv) a_phase = 2;
    end else if (in_r) begin
      if (s_if.rvalid && rready_drv[g]) begin
        beats[g]++;
        last_data[g] = s_if.rdata;
        if (s_if.rlast) begin
          check("burst_len", 64'(beats[g]), 64'(exp_ar.len) + 64'd1);
          a_phase = 0;
          a_prio  = 1 - g;
        end
      end
      rr_idx++;
    end

    if (s_have && s_offer && s_if.rready) begin
      s_offer = 1'b0;
      if (s_cnt == s_len) s_have = 1'b0;
      else s_cnt++;
    end
    if (s_if.arvalid) begin
      if (s_arready_drv) begin
        s_have  = 1'b1;
        s_len   = int'(s_if.arlen);
        s_id    = s_if.arid;
        s_cnt   = 0;
        s_offer = 1'b0;
        s_dly   = new_dly();
      end else if (s_dly > 0) begin
        s_dly--;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = (q0.size() == 0) && (q1.size() == 0) && !pend[0] && !pend[1] && (a_phase == 0);
    end
    check({tag, "_complete"}, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();

    // Held reset with both masters requesting and the slave offering data
    rst = 1'b0;
    m0_if.arvalid = 1'b1;
    m1_if.arvalid = 1'b1;
    m0_if.rready  = 1'b1;
    m1_if.rready  = 1'b1;
    s_if.arready  = 1'b1;
    s_if.rvalid   = 1'b1;
    s_if.rlast    = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_m0_arready", 64'(m0_if.arready), 64'd0);
      check("rst_m1_arready", 64'(m1_if.arready), 64'd0);
      check("rst_s_arvalid", 64'(s_if.arvalid), 64'd0);
      check("rst_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
      check("rst_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
      check("rst_s_rready", 64'(s_if.rready), 64'd0);
      check("rst_s_araddr", 64'(s_if.araddr), 64'd0);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    model_reset();
    rst = 1'b1;

    // Single m0 burst, slave address ready after two cycles, beats 0x11..0x44
    dly_fixed = 2; s_dly = 2; rv_always = 1'b1; fixed_data = 1'b1; junk_en = 1'b0; rr_mode = 2;
    q0.push_back(mk_ar(32'h8000_0010, 4'h3, 8'd3));
    run_idle("single_m0", 200);
    check("single_m0_beats", 64'(beats[0]), 64'd4);
    check("single_m0_last", 64'(last_data[0]), 64'h44);
    check("single_m1_beats", 64'(beats[1]), 64'd0);

    // Simultaneous requests right after reset: m0 first, then m1
    do_reset();
    dly_fixed = 1; fixed_data = 1'b0;
    q0.push_back(mk_ar(32'h0000_1000, 4'h1, 8'd2));
    q1.push_back(mk_ar(32'h0000_2000, 4'h2, 8'd1));
    run_idle("simul", 200);
    check("simul_ngrants", 64'(glog.size()), 64'd2);
    check("simul_first", 64'(glog[0]), 64'd0);
    check("simul_second", 64'(glog[1]), 64'd1);

    // Fairness: m0 keeps requesting, m1 once
    glog.delete();
    q0.push_back(mk_ar(32'h0000_3000, 4'h4, 8'd1));
    q0.push_back(mk_ar(32'h0000_3100, 4'h5, 8'd0));
    q1.push_back(mk_ar(32'h0000_4000, 4'h6, 8'd2));
    run_idle("fair", 200);
    check("fair_ngrants", 64'(glog.size()), 64'd3);
    check("fair_g0", 64'(glog[0]), 64'd0);
    check("fair_g1", 64'(glog[1]), 64'd1);
    check("fair_g2", 64'(glog[2]), 64'd0);

    // Backpressure: m1 two-beat burst with rready pattern 1,0,0,1
    rr_mode = 1; rr_idx = 0;
    q1.push_back(mk_ar(32'h0000_5000, 4'h7, 8'd1));
    run_idle("bp", 200);
    check("bp_beats", 64'(beats[1]), 64'd2);

    // Randomized traffic with stray slave rvalid outside bursts
    dly_fixed = -1; rv_always = 1'b0; junk_en = 1'b1; rr_mode = 0; rand_issue = 1'b1;
    for (int i = 0; i < 15; i++) begin
      q0.push_back(mk_ar($urandom(), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 7))));
      q1.push_back(mk_ar($urandom(), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 7))));
    end
    run_idle("random", 5000);

    // Reset asserted between beats 2 and 3 of a four-beat m0 burst
    dly_fixed = 1; rv_always = 1'b1; junk_en = 1'b0; rr_mode = 2; rand_issue = 1'b0;
    beats[0] = 0; beats[1] = 0;
    q0.push_back(mk_ar(32'h0000_6000, 4'h8, 8'd3));
    begin
      int n;
      n = 0;
      while (beats[0] < 2 && n < 200) begin
        cycle();
        n++;
      end
      check("midrst_reached_beat2", 64'(beats[0] >= 2), 64'd1);
    end
    @(posedge clk);
    #1;
    drive();
    #2;
    check("midrst_pre_m0_rvalid", 64'(m0_if.rvalid), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
    check("midrst_s_rready", 64'(s_if.rready), 64'd0);
    check("midrst_s_arvalid", 64'(s_if.arvalid), 64'd0);
    check("midrst_s_araddr", 64'(s_if.araddr), 64'd0);
    check("midrst_m0_rpayload", 64'({m0_if.rdata, m0_if.rresp, m0_if.rlast, m0_if.rid}), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    q1.push_back(mk_ar(32'h0000_7000, 4'h9, 8'd2));
    run_idle("post_rst", 200);
    check("post_rst_beats", 64'(beats[1]), 64'd3);
    check("post_rst_ngrants", 64'(glog.size()), 64'd1);
    check("post_rst_grant", 64'(glog[0]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
